// File: rtl/idex_pipe_stage.sv
// ---------------------------------------------------------------------------
// idex_pipe_stage
//   ID/EX pipeline stage register with a valid/ready handshake on both sides,
//   a two-entry skid buffer (main + skid) and a flush input for squashing
//   wrong-path or excepting instructions. Because in_ready is a flop,
//   backpressure from execute never reaches decode combinationally.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (highest priority)
//   flush      squash every held entry
//   in_valid   decode presents an entry
//   in_ready   stage can accept an entry (registered)
//   in_data    NUM_FIELDS packed data words, field 0 in the LSBs
//   in_ctrl    control bundle
//   out_valid  execute-side entry valid (registered)
//   out_ready  execute accepts the presented entry
//   out_data   packed data words of the oldest entry
//   out_ctrl   control bundle of the oldest entry
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
// ---------------------------------------------------------------------------
module idex_pipe_stage #(
  parameter int DATA_W      = 32,
  parameter int NUM_FIELDS  = 3,
  parameter int CTRL_W      = 16,
  parameter int ZERO_BUBBLE = 1,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]            in_ctrl,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_FIELDS*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int DW = NUM_FIELDS * DATA_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [DW-1:0]     main_data_r, main_data_s;
  logic [CTRL_W-1:0] main_ctrl_r, main_ctrl_s;
  logic [DW-1:0]     skid_data_r, skid_data_s;
  logic [CTRL_W-1:0] skid_ctrl_r, skid_ctrl_s;
  logic              in_ready_r, in_ready_s;
  logic              out_valid_r, out_valid_s;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              push_s;
  logic              pop_s;

  // Handshake qualifiers, both built from registered readiness/validity.
  always_comb begin
    push_s = in_valid & in_ready_r;
    pop_s  = out_valid_r & out_ready;
  end

  // Next-state, storage update and registered-output precomputation.
  always_comb begin
    state_s     = state_r;
    main_data_s = main_data_r;
    main_ctrl_s = main_ctrl_r;
    skid_data_s = skid_data_r;
    skid_ctrl_s = skid_ctrl_r;

    case (state_r)
      ST_EMPTY: begin
        if (push_s) begin
          state_s     = ST_ONE;
          main_data_s = in_data;
          main_ctrl_s = in_ctrl;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (push_s && pop_s) begin
          state_s     = ST_ONE;
          main_data_s = in_data;
          main_ctrl_s = in_ctrl;
        end else if (push_s) begin
          state_s     = ST_TWO;
          skid_data_s = in_data;
          skid_ctrl_s = in_ctrl;
        end else if (pop_s) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_ONE;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so no push can arrive.
        if (pop_s) begin
          state_s     = ST_ONE;
          main_data_s = skid_data_r;
          main_ctrl_s = skid_ctrl_r;
        end else begin
          state_s = ST_TWO;
        end
      end
      default: begin
        state_s = ST_EMPTY;
      end
    endcase

    // Flush overrides the handshake result; a same-cycle pop has already
    // been sampled by execute, and any same-cycle push is simply dropped.
    if (flush) begin
      state_s = ST_EMPTY;
      if (ZERO_BUBBLE != 0) begin
        main_data_s = {DW{1'b0}};
        main_ctrl_s = {CTRL_W{1'b0}};
        skid_data_s = {DW{1'b0}};
        skid_ctrl_s = {CTRL_W{1'b0}};
      end else begin
        main_data_s = main_data_r;
        main_ctrl_s = main_ctrl_r;
        skid_data_s = skid_data_r;
        skid_ctrl_s = skid_ctrl_r;
      end
    end else begin
      state_s = state_s;
    end

    // Clearing main whenever the stage drains keeps out_data/out_ctrl
    // driven straight from flops while still reading zero in a bubble.
    if ((ZERO_BUBBLE != 0) && (state_s == ST_EMPTY)) begin
      main_data_s = {DW{1'b0}};
      main_ctrl_s = {CTRL_W{1'b0}};
    end else begin
      main_data_s = main_data_s;
      main_ctrl_s = main_ctrl_s;
    end

    in_ready_s  = (state_s != ST_TWO);
    out_valid_s = (state_s != ST_EMPTY);
  end

  // State, storage and handshake flops; rst outranks flush and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      main_data_r <= {DW{1'b0}};
      main_ctrl_r <= {CTRL_W{1'b0}};
      skid_data_r <= {DW{1'b0}};
      skid_ctrl_r <= {CTRL_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      main_data_r <= main_data_s;
      main_ctrl_r <= main_ctrl_s;
      skid_data_r <= skid_data_s;
      skid_ctrl_r <= skid_ctrl_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

  // Stall performance counter: saturates at all-ones, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (out_valid_r && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_data_r;
  assign out_ctrl  = main_ctrl_r;
  assign stall_cnt = stall_cnt_r;

endmodule
